// File: rtl/rot_right_rr_arb.sv
// rot_right_rr_arb
//   Registered round-robin arbiter with packet-level locking, placed in front
//   of a router output's switch allocator. The request vector is rotated right
//   by the priority pointer. A fixed-priority pick then takes the lowest set
//   bit, and the winner is mapped back to an absolute port index. Once a port
//   is granted, it keeps the grant until it drops its request bit.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   request      per-port request, held high by the owner for the whole packet
//   grant        registered one-hot grant (or all zeros)
//   grant_valid  high when any grant bit is set
//   grant_id     binary index of the granted port (0 when grant_valid=0)
//
// Build option
//   RR_X_IN_FAST_REARB_EN  when defined, the release cycle immediately
//                          re-arbitrates among the remaining requesters, so no
//                          zero-grant bubble appears between packets.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner; arbitrate over request each cycle
// GRANTED | grant_id owns the output until request[grant_id] drops

module rot_right_rr_arb #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_SIZE-1:0] request,
  output logic [IO_SIZE-1:0] grant,
  output logic               grant_valid,
  output logic [IO_w-1:0]    grant_id
);

  typedef enum logic {IDLE, GRANTED} state_t;

  localparam logic [IO_w:0] SIZE_W = (IO_w+1)'(IO_SIZE);

  state_t             state, state_nxt;
  logic [IO_w-1:0]    pointer, pointer_nxt;
  logic [IO_SIZE-1:0] grant_nxt;
  logic               grant_valid_nxt;
  logic [IO_w-1:0]    grant_id_nxt;

  logic [IO_SIZE-1:0] arb_req;
  logic [IO_w-1:0]    arb_ptr;
  logic [IO_SIZE-1:0] rotated;
  logic               arb_found;
  logic [IO_w-1:0]    arb_k;
  logic [IO_w-1:0]    arb_winner;
  logic [IO_w-1:0]    ptr_inc;
  logic               owner_held;

  // Pointer value after the current owner releases.
  assign ptr_inc    = (grant_id == IO_w'(IO_SIZE-1)) ? '0 : grant_id + 1'b1;
  assign owner_held = request[grant_id];

  // Arbiter inputs. In the fast build, the release cycle arbitrates with the
  // releasing port masked off, and with the pointer it is about to take.
  always_comb begin
    arb_req = request;
    arb_ptr = pointer;
`ifdef RR_X_IN_FAST_REARB_EN
    if (state == GRANTED) begin
      arb_req = request & ~grant;
      arb_ptr = ptr_inc;
    end
`endif
  end

  // Rotate right by arb_ptr. The indices wrap with compare-subtract, so any
  // IO_SIZE works, not only powers of two.
  always_comb begin
    logic [IO_w:0] idx;
    idx     = '0;
    rotated = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      idx = {1'b0, arb_ptr} + (IO_w+1)'(i);
      if (idx >= SIZE_W) idx = idx - SIZE_W;
      rotated[i] = arb_req[idx[IO_w-1:0]];
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_k     = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      if (!arb_found && rotated[i]) begin
        arb_found = 1'b1;
        arb_k     = IO_w'(i);
      end
    end
  end

  // Map the rotated index back to an absolute port.
  always_comb begin
    logic [IO_w:0] sum;
    sum = {1'b0, arb_ptr} + {1'b0, arb_k};
    if (sum >= SIZE_W) sum = sum - SIZE_W;
    arb_winner = sum[IO_w-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pointer     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_nxt;
      pointer     <= pointer_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pointer_nxt     = pointer;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    grant_id_nxt    = grant_id;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nxt       = IO_SIZE'(1) << arb_winner;
          grant_valid_nxt = 1'b1;
          grant_id_nxt    = arb_winner;
          state_nxt       = GRANTED;
        end else begin
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          grant_id_nxt    = '0;
        end
      end
      GRANTED: begin
        if (!owner_held) begin
          pointer_nxt     = ptr_inc;
          grant_nxt       = '0;
          grant_valid_nxt = 1'b0;
          grant_id_nxt    = '0;
          state_nxt       = IDLE;
`ifdef RR_X_IN_FAST_REARB_EN
          if (arb_found) begin
            grant_nxt       = IO_SIZE'(1) << arb_winner;
            grant_valid_nxt = 1'b1;
            grant_id_nxt    = arb_winner;
            state_nxt       = GRANTED;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rot_right_rr_arb.sv
`timescale 1ns/1ps
module tb_rot_right_rr_arb;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: priority pointer and current owner (-1 = none).
  int m_ptr   = 0;
  int m_owner = -1;

  rot_right_rr_arb #(.IO_SIZE(N), .IO_w(3)) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // First requesting port, searching upward from ptr and wrapping.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int j = 0; j < N; j++)
      if (req[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int owner);
    return (owner >= 0) ? (N'(1) << owner) : '0;
  endfunction

  task automatic model_update(input logic [N-1:0] req);
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
`ifdef RR_X_IN_FAST_REARB_EN
      m_owner = pick(req & ~(N'(1) << m_owner), m_ptr);
`else
      m_owner = -1;
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] req);
    request = req;
    @(posedge clk);
    model_update(req);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_ptr   = 0;
    m_owner = -1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    step(5'b11111);
    n_checks++;
    if (grant !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b want 00001", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 5'b0 || grant_valid !== 1'b0 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_async: got grant=%b valid=%b id=%0d want 0/0/0", grant, grant_valid, grant_id);
    end
    rst = 1'b0;
    m_ptr = 0; m_owner = -1;
    step(5'b11111);
    n_checks++;
    if (grant !== 5'b00001 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_regrant: got grant=%b id=%0d want 00001/0", grant, grant_id);
    end
  endtask

  task automatic test_basic_wrap();
    do_reset();
    step(5'b10100);
    n_checks++;
    if (grant !== 5'b00100 || grant_id !== 3'd2 || grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant: got grant=%b id=%0d valid=%b want 00100/2/1", grant, grant_id, grant_valid);
    end
    step(5'b10110);
    n_checks++;
    if (grant !== 5'b00100) begin
      n_fail++;
      $display("FAIL basic_hold: got %b want 00100", grant);
    end
    step(5'b00000);
    n_checks++;
    if (grant !== 5'b0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: got grant=%b valid=%b want 0/0", grant, grant_valid);
    end
    step(5'b10101);
    n_checks++;
    if (grant_id !== 3'd4 || grant !== 5'b10000) begin
      n_fail++;
      $display("FAIL wrap_grant: got id=%0d grant=%b want 4/10000", grant_id, grant);
    end
    step(5'b00000);
    step(5'b00101);
    n_checks++;
    if (grant_id !== 3'd0 || grant !== 5'b00001) begin
      n_fail++;
      $display("FAIL wrap_pointer0: got id=%0d grant=%b want 0/00001", grant_id, grant);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int pkt = 0; pkt < 6; pkt++) begin
      int t;
      int g;
      t = 0;
      while (!grant_valid && t < 4) begin
        step(5'b11111);
        t++;
      end
      n_checks++;
      if (grant_valid !== 1'b1 || grant_id !== 3'(pkt % N)) begin
        n_fail++;
        $display("FAIL fairness_pkt%0d: got valid=%b id=%0d want 1/%0d", pkt, grant_valid, grant_id, pkt % N);
      end
      g = int'(grant_id);
      step(5'b11111);
      step(5'b11111 & ~(5'b00001 << g));
    end
  endtask

  task automatic test_async_mid();
    do_reset();
    step(5'b01000);
    n_checks++;
    if (grant !== 5'b01000) begin
      n_fail++;
      $display("FAIL async_setup: got %b want 01000", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 5'b0 || grant_valid !== 1'b0 || grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL async_clear: got grant=%b valid=%b id=%0d want 0/0/0", grant, grant_valid, grant_id);
    end
    rst = 1'b0;
    m_ptr = 0; m_owner = -1;
    step(5'b11111);
    n_checks++;
    if (grant !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_pointer0: got %b want 00001", grant);
    end
  endtask

  task automatic test_rearb();
    do_reset();
    step(5'b01010);
    n_checks++;
    if (grant !== 5'b00010) begin
      n_fail++;
      $display("FAIL rearb_setup: got %b want 00010", grant);
    end
    step(5'b01000);
`ifdef RR_X_IN_FAST_REARB_EN
    n_checks++;
    if (grant !== 5'b01000) begin
      n_fail++;
      $display("FAIL rearb_fast: got %b want 01000", grant);
    end
`else
    n_checks++;
    if (grant !== 5'b0) begin
      n_fail++;
      $display("FAIL rearb_bubble: got %b want 00000", grant);
    end
    step(5'b01000);
    n_checks++;
    if (grant !== 5'b01000) begin
      n_fail++;
      $display("FAIL rearb_after_bubble: got %b want 01000", grant);
    end
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    logic [2:0]   eid;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom);
      if (m_owner >= 0 && $urandom_range(3, 0) != 0) r[m_owner] = 1'b1;
      step(r);
      eg  = exp_grant(m_owner);
      eid = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      n_checks++;
      if (grant !== eg || grant_valid !== (m_owner >= 0) || grant_id !== eid) begin
        n_fail++;
        $display("FAIL random_c%0d: req=%b got grant=%b valid=%b id=%0d want %b/%0d/%0d",
                 c, r, grant, grant_valid, grant_id, eg, (m_owner >= 0), eid);
      end
      n_checks++;
      if ($countones(grant) > 1) begin
        n_fail++;
        $display("FAIL random_onehot_c%0d: got %b want at most one bit", c, grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_wrap();
    test_fairness();
    test_async_mid();
    test_rearb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
